// File: rtl/mux_arb_n_if.sv
// Handshake bundle for the N-way registered channel mux/arbiter.
// The master drives the input channels and the consumer ready; the slave is the mux.
interface mux_arb_n_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = 2
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_chan;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_arb_n.sv
// N-way, WIDTH-bit channel multiplexer with a single output register stage.
// Fixed mode picks the channel from sel; round-robin mode searches in_valid
// starting at ptr and advances ptr past each round-robin winner.

// Per-channel ready: a channel sees ready only when it holds the grant and
// the output stage can take a beat.
module mux_arb_n_lane #(
    parameter int SELW = 2,
    parameter int IDX  = 0
) (
    input  logic            grant_vld_i,
    input  logic [SELW-1:0] grant_i,
    input  logic            can_accept_i,
    output logic            ready_o
);
    assign ready_o = grant_vld_i && (grant_i == SELW'(IDX)) && can_accept_i;
endmodule

module mux_arb_n #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    mux_arb_n_if.slave  bus
);
    localparam int NPAD = 1 << SELW;

    logic [WIDTH-1:0]           out_data_q, out_data_d;
    logic [SELW-1:0]            out_chan_q, out_chan_d;
    logic                       out_valid_q, out_valid_d;
    logic [SELW-1:0]            ptr_q, ptr_d;

    logic                       can_accept;
    logic                       grant_vld;
    logic [SELW-1:0]            grant;
    logic                       xfer;
    logic [N-1:0]               in_ready;
    int                         rr_idx;

    // Channels padded out to the full select range so a SELW-bit index is
    // always in bounds; phantom channels are never valid.
    logic [NPAD-1:0]            valid_pad;
    logic [NPAD-1:0][WIDTH-1:0] data_pad;

    genvar i;
    generate
        for (i = 0; i < NPAD; i++) begin : g_pad
            if (i < N) begin : g_real
                assign valid_pad[i] = bus.in_valid[i];
                assign data_pad[i]  = bus.in_data[i*WIDTH +: WIDTH];
            end else begin : g_phantom
                assign valid_pad[i] = 1'b0;
                assign data_pad[i]  = '0;
            end
        end
        for (i = 0; i < N; i++) begin : g_lane
            mux_arb_n_lane #(.SELW(SELW), .IDX(i)) u_lane (
                .grant_vld_i  (grant_vld),
                .grant_i      (grant),
                .can_accept_i (can_accept),
                .ready_o      (in_ready[i])
            );
        end
    endgenerate

    // No handshake may complete while reset is asserted.
    assign can_accept = rst_n && (!out_valid_q || bus.out_ready);

    // Grant selection: sel in fixed mode, first valid at/after ptr in round-robin.
    // The search runs from the farthest offset down so the nearest valid wins.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        rr_idx    = 0;
        if (!bus.mode) begin
            if (int'(bus.sel) < N) begin
                grant_vld = 1'b1;
                grant     = bus.sel;
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                rr_idx = int'(ptr_q) + k;
                if (rr_idx >= N) rr_idx = rr_idx - N;
                if (valid_pad[SELW'(rr_idx)]) begin
                    grant_vld = 1'b1;
                    grant     = SELW'(rr_idx);
                end
            end
        end
    end

    assign xfer = grant_vld && valid_pad[grant] && can_accept;

    // Output stage next state: load on transfer (replacing a draining beat),
    // clear valid on a plain drain, otherwise hold.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = data_pad[grant];
            out_chan_d  = grant;
            out_valid_d = 1'b1;
            if (bus.mode) ptr_d = (int'(grant) == N - 1) ? '0 : grant + 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any buffered beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: a spec-level model predicts grants and
// in_ready, accepted beats go into a scoreboard queue and are compared when
// the DUT presents them. A second N=3 instance covers out-of-range select.
module tb_mux_arb_n;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_arb_n_if #(.WIDTH(32), .N(4), .SELW(2)) b ();
    mux_arb_n_if #(.WIDTH(32), .N(3), .SELW(2)) b3 ();

    mux_arb_n #(.WIDTH(32), .N(4), .SELW(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(b));
    mux_arb_n #(.WIDTH(32), .N(3), .SELW(2)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    typedef struct {
        logic [31:0] data;
        logic [1:0]  chan;
    } beat_t;

    beat_t sb[$];
    int    vectors = 0;
    int    miscompares = 0;
    logic  m_ov = 1'b0;
    int    m_ptr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int ch, input logic [31:0] v);
        b.in_data[ch*32 +: 32] = v;
    endtask

    // Spec-level grant: returns {found, index}.
    function automatic logic [4:0] mgrant(input logic md, input int s, input logic [3:0] v, input int p);
        if (!md) return (s < 4) ? {1'b1, 2'b0, s[1:0]} : 5'b0;
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (p + k) % 4;
            if (v[c]) return {1'b1, 2'b0, c[1:0]};
        end
        return 5'b0;
    endfunction

    // One clock: check combinational ready and the output stage before the
    // edge, update the model, then advance past the edge.
    task automatic step(input int want = -1);
        logic [4:0] g;
        logic       can, xf;
        logic [3:0] er;
        @(negedge clk);
        g   = mgrant(b.mode, int'(b.sel), b.in_valid, m_ptr);
        can = !m_ov || b.out_ready;
        er  = (can && g[4]) ? (4'b0001 << g[1:0]) : 4'b0000;
        chk("in_ready", 32'(b.in_ready), 32'(er));
        if (want >= 0) chk("plan_ready", 32'(b.in_ready), want);
        chk("out_valid", 32'(b.out_valid), 32'(m_ov));
        if (m_ov) begin
            if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
            else begin
                chk("out_data", b.out_data, sb[0].data);
                chk("out_chan", 32'(b.out_chan), 32'(sb[0].chan));
            end
        end
        xf = (er != 4'b0) && b.in_valid[g[1:0]];
        if (m_ov && b.out_ready) begin
            if (sb.size() != 0) void'(sb.pop_front());
            m_ov = 1'b0;
        end
        if (xf) begin
            sb.push_back('{data: b.in_data[g[1:0]*32 +: 32], chan: g[1:0]});
            m_ov = 1'b1;
            if (b.mode) m_ptr = (int'(g[1:0]) + 1) % 4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk("rst_in_ready", 32'(b.in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk("rst_out_valid", 32'(b.out_valid), 32'd0);
            chk("rst_out_data", b.out_data, 32'd0);
            chk("rst_out_chan", 32'(b.out_chan), 32'd0);
        end
        rst_n = 1'b1;
        m_ov = 1'b0;
        m_ptr = 0;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b.mode = 1'b1; b.sel = 2'd0; b.in_valid = 4'b1111; b.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_data(i, 32'hA000_0000 + 32'(i));
        b3.mode = 1'b0; b3.sel = 2'd3; b3.in_valid = 3'b111; b3.out_ready = 1'b1;
        b3.in_data = {32'h3333_0002, 32'h0000_5A5A, 32'h3333_0000};

        // Reset held two clocks with every channel requesting.
        do_reset(2);

        // N=3 instance: sel=3 is out of range, then sel=1 is a normal grant.
        b.in_valid = 4'b0000;
        repeat (2) begin
            @(negedge clk);
            chk("n3_oor_ready", 32'(b3.in_ready), 32'd0);
            chk("n3_oor_valid", 32'(b3.out_valid), 32'd0);
            @(posedge clk); #1;
        end
        b3.sel = 2'd1;
        @(negedge clk);
        chk("n3_sel1_ready", 32'(b3.in_ready), 32'b010);
        @(posedge clk); #1;
        chk("n3_sel1_valid", 32'(b3.out_valid), 32'd1);
        chk("n3_sel1_data", b3.out_data, 32'h0000_5A5A);
        chk("n3_sel1_chan", 32'(b3.out_chan), 32'd1);
        b3.in_valid = 3'b000;

        // First round-robin grant after reset is ch0.
        b.in_valid = 4'b1111;
        step(4'b0001);

        // Fixed select ch2, sustained one beat per clock.
        b.mode = 1'b0; b.sel = 2'd2;
        for (int k = 0; k < 4; k++) begin
            set_data(2, 32'hDEADBEEF + 32'(k));
            step(4'b0100);
        end

        // Round-robin fairness, all four requesting.
        do_reset(1);
        b.mode = 1'b1; b.in_valid = 4'b1111;
        begin
            int seq[6] = '{0, 1, 2, 3, 0, 1};
            for (int k = 0; k < 6; k++) begin
                for (int c = 0; c < 4; c++) set_data(c, 32'hB000_0000 + 32'(k*16 + c));
                step(1 << seq[k]);
            end
        end
        // ch1 drops out.
        do_reset(1);
        b.in_valid = 4'b1101;
        begin
            int seq2[5] = '{0, 2, 3, 0, 2};
            for (int k = 0; k < 5; k++) begin
                for (int c = 0; c < 4; c++) set_data(c, 32'hC000_0000 + 32'(k*16 + c));
                step(1 << seq2[k]);
            end
        end

        // Backpressure: 0x11 held for three clocks, then drains with no bubble.
        b.mode = 1'b0; b.sel = 2'd0; b.in_valid = 4'b1111; set_data(0, 32'h11);
        step();
        b.out_ready = 1'b0; set_data(0, 32'h22);
        repeat (3) step(0);
        b.out_ready = 1'b1;
        step(4'b0001);
        set_data(0, 32'h33);
        step();

        // Mode switch while stalled: held beat untouched, next grant follows ptr (3).
        b.sel = 2'd1; set_data(1, 32'h44);
        step();
        b.out_ready = 1'b0; b.mode = 1'b1; b.sel = 2'd0;
        repeat (2) step(0);
        b.out_ready = 1'b1;
        step(4'b1000);

        // Reset mid-operation with a stalled 0xCAFE beat and ptr=2.
        b.in_valid = 4'b0010; set_data(1, 32'hCAFE);
        step(4'b0010);
        b.out_ready = 1'b0;
        step(0);
        do_reset(1);
        b.out_ready = 1'b1; b.in_valid = 4'b1111;
        step(4'b0001);
        step(4'b0010);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
- Parametrised N-way, WIDTH-bit registered channel multiplexer with valid/ready handshakes on every input and on the output.
- Two selection modes, switchable at runtime:
  - fixed: an external select picks the channel, like the datapath muxes.
  - round-robin: fair arbitration among the requesting channels.
- One output register stage, one-cycle latency, full throughput.
- Sits between multicycle datapath producers (ALU, memory, register-file paths) and a shared consumer.

Parameters:
- WIDTH, 32, data width per channel.
- N, 4, number of input channels (N >= 2).
- SELW, 2, select/channel-index width; must satisfy 2**SELW >= N.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready (combinational)
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SELW  channel index, used when mode=0
- out_data  output  WIDTH  registered selected data
- out_chan  output  SELW  index of the channel that produced out_data
- out_valid  output  1  out_data holds a beat
- out_ready  input  1  consumer accepts the beat

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_chan=0, round-robin pointer ptr=0. Reset wins over any same-cycle transfer; a buffered beat is discarded.
- can_accept = !out_valid | out_ready.
- Fixed mode (mode=0):
  - grant = sel when sel < N.
  - in_ready[sel] = can_accept; all other in_ready bits = 0.
  - sel >= N: no grant, in_ready all 0.
- Round-robin mode (mode=1):
  - Search in_valid starting at index ptr, wrapping N-1 -> 0.
  - grant = first valid index found; in_ready[grant] = can_accept; all other in_ready bits = 0.
  - No valid input: in_ready all 0.
- Input transfer: in_valid[grant] & in_ready[grant]. On the next edge: out_data <= channel data, out_chan <= grant, out_valid <= 1.
- Output drain without a new input transfer (out_valid & out_ready): out_valid <= 0. out_data and out_chan hold their last values.
- Simultaneous drain and input transfer: the new beat replaces the old in the same cycle. Back-to-back throughput is 1 beat/clk.
- Stall (out_valid & !out_ready): out_data, out_chan and out_valid hold; in_ready is all 0.
- ptr update: only on a round-robin input transfer, ptr <= (grant == N-1) ? 0 : grant+1. Fixed-mode transfers leave ptr unchanged.
- Mode or sel changes:
  - Sampled combinationally each cycle; affect only the next grant.
  - A buffered beat is never altered.
  - Changing sel while stalled is legal.
- Latency: input transfer at edge k -> out_valid at edge k (visible after k), consumable from cycle k+1.
- in_ready never depends on in_valid of non-granted channels in fixed mode. In round-robin mode, in_ready depends on in_valid; the bench must not create a loop through in_valid.
- No overflow or loss: a beat is only accepted when the stage is empty or draining.
- out_data bits are don't-care while out_valid=0, except that after reset they are 0.

Test Plan:
1. Reset: hold rst_n=0 for 2 clks with all in_valid=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=0 during reset. After release, mode=1 grants ch0 first.
2. Fixed mode, sel=2: in_data ch2=0xDEADBEEF, in_valid=4'b1111, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=0xDEADBEEF, out_chan=2, out_valid=1. Sustained 1 beat/clk.
3. Round-robin fairness: all four valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,1. Drop ch1 valid -> sequence 0,2,3,0,2.
4. Backpressure: out_ready=0 for 3 clks with out_valid=1, out_data=0x11 -> in_ready=0, out_data stays 0x11. Raise out_ready -> 0x11 drains; the next beat follows with no bubble.
5. Out-of-range / mid-stream changes:
   - N=3, SELW=2, mode=0, sel=3 -> in_ready=0, out_valid stays 0.
   - Switch mode 0->1 while stalled -> the held beat is unchanged; the next grant follows ptr.
6. Reset mid-operation: out_valid=1 with a stalled beat 0xCAFE, ptr=2, rst_n=0 for one edge -> out_valid=0, out_data=0, ptr=0. The first round-robin grant afterwards is ch0.
